// File: rtl/pc_sequencer_pkg.sv
// Shared PC types, reset vector and next-PC source encoding for the fetch head.
package pc_sequencer_pkg;

  localparam int PC_XLEN = 32;

  typedef logic [PC_XLEN-1:0] rv32_pc_t;

  localparam rv32_pc_t PC_RESET_VECTOR = 32'h0000_0000;

  // Source that produced next_pc; kept as an enum so a debug probe can decode it.
  typedef enum logic [2:0] {
    PC_RESET,
    PC_TRAP,
    PC_REDIRECT,
    PC_HOLD,
    PC_RAS,
    PC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_sequencer_return_addr_stack.sv
// Circular return-address stack: a wrap-around top pointer plus a saturating count.
module return_addr_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][XLEN-1:0] mem;
  logic [PW-1:0]                  ptr;
  logic [PW-1:0]                  ptr_inc;
  logic [PW:0]                    cnt;
  logic                           do_pop;

  assign ptr_inc = ptr + 1'b1;
  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(RAS_DEPTH));
  assign top     = mem[ptr];
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !do_pop) begin
      // A push into a full stack overwrites the oldest slot; count saturates.
      ptr <= ptr_inc;
      if (!full) cnt <= cnt + 1'b1;
    end else if (do_pop && !push) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  // Storage carries no reset; the count alone marks which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (do_pop) mem[ptr]     <= push_data;
      else        mem[ptr_inc] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: prioritised next-PC mux with alignment and RAS prediction.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int             XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter int             INC          = 4,
  parameter int             RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            call_hint,
  input  logic [XLEN-1:0] call_link,
  input  logic            ret_hint,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int              AW         = $clog2(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INC - 1);

  pc_src_e         pc_src;
  logic            mis_nxt;
  logic            ras_en;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;

  // Calls resolve as redirects, so a redirect does not block the push.
  assign ras_en   = pc_valid && !rst && !trap_valid && !redirect_valid && !stall;
  assign ras_push = call_hint && (ras_en || (pc_valid && !rst && !trap_valid && redirect_valid));
  assign ras_pop  = ret_hint && ras_en && !ras_empty;

  always_comb begin
    pc_src = PC_SEQ;
    if (rst || !pc_valid)   pc_src = PC_RESET;
    else if (trap_valid)    pc_src = PC_TRAP;
    else if (redirect_valid) pc_src = PC_REDIRECT;
    else if (stall)         pc_src = PC_HOLD;
    else if (ras_pop)       pc_src = PC_RAS;
  end

  always_comb begin
    next_pc = pc + XLEN'(INC);
    mis_nxt = 1'b0;
    case (pc_src)
      PC_RESET:    next_pc = RESET_VECTOR;
      PC_TRAP: begin
        next_pc = trap_vector & ALIGN_MASK;
        mis_nxt = |trap_vector[AW-1:0];
      end
      PC_REDIRECT: begin
        next_pc = redirect_pc & ALIGN_MASK;
        mis_nxt = |redirect_pc[AW-1:0];
      end
      PC_HOLD:     next_pc = pc;
      PC_RAS:      next_pc = ras_top;
      default:     next_pc = pc + XLEN'(INC);
    endcase
  end

  // The first free edge after reset only raises pc_valid (bubble at RESET_VECTOR).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      pc_valid   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      pc         <= next_pc;
      pc_valid   <= 1'b1;
      misaligned <= mis_nxt;
    end
  end

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (call_link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset bubble, priority mux, alignment, stall and RAS.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        call_hint;
  logic [31:0] call_link;
  logic        ret_hint;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_valid;
  logic        misaligned;
  logic        ras_empty;
  logic        ras_full;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .INC          (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .call_hint      (call_hint),
    .call_link      (call_link),
    .ret_hint       (ret_hint),
    .pc             (pc),
    .next_pc        (next_pc),
    .pc_valid       (pc_valid),
    .misaligned     (misaligned),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_vector = '0; call_hint = 1'b0; call_link = '0; ret_hint = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    end
    chk("rst_ras_empty", {31'b0, ras_empty}, 32'd1);
    chk("rst_ras_full", {31'b0, ras_full}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);

    rst = 1'b0;
    tick();
    chk("bubble_valid", {31'b0, pc_valid}, 32'd1);
    chk("bubble_pc", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", pc, 32'(4 * i));
    end
    chk("seq_next_pc", next_pc, 32'd16);

    // Aligned redirect then free-run
    redirect_valid = 1'b1; redirect_pc = 32'h1000_ABC0;
    #1 chk("redir_next_pc", next_pc, 32'h1000_ABC0);
    tick(); redirect_valid = 1'b0;
    chk("redir_pc", pc, 32'h1000_ABC0);
    chk("redir_mis", {31'b0, misaligned}, 32'd0);
    tick();
    chk("redir_seq", pc, 32'h1000_ABC4);
    chk("redir_seq_mis", {31'b0, misaligned}, 32'd0);

    // Trap beats redirect in the same cycle
    trap_valid = 1'b1; trap_vector = 32'h4000_0000;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2048;
    tick(); trap_valid = 1'b0;
    chk("trap_pc", pc, 32'h4000_0000);
    tick(); redirect_valid = 1'b0;
    chk("trap_then_redir", pc, 32'h0000_2048);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2046;
    tick(); redirect_valid = 1'b0;
    chk("mis_pc", pc, 32'h0000_2044);
    chk("mis_flag", {31'b0, misaligned}, 32'd1);
    tick();
    chk("mis_pc2", pc, 32'h0000_2048);
    chk("mis_clear", {31'b0, misaligned}, 32'd0);

    // Seed one RAS entry, then stall with a ret_hint: no pop may happen
    call_hint = 1'b1; call_link = 32'h78;
    tick(); call_hint = 1'b0;
    chk("push1_pc", pc, 32'h0000_204C);
    chk("push1_nonempty", {31'b0, ras_empty}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); redirect_valid = 1'b0;
    chk("stall_entry", pc, 32'h100);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ret_hint = (i == 1);
      tick();
      chk("stall_pc", pc, 32'h100);
      chk("stall_ras", {31'b0, ras_empty}, 32'd0);
    end
    stall = 1'b0; ret_hint = 1'b1;
    tick(); ret_hint = 1'b0;
    chk("ret_after_stall", pc, 32'h78);
    chk("ret_after_stall_empty", {31'b0, ras_empty}, 32'd1);

    // Five pushes into a four-deep stack, then five returns
    for (int i = 1; i <= 5; i++) begin
      call_hint = 1'b1; call_link = 32'(16 * i);
      tick();
      chk("push_pc", pc, 32'h78 + 32'(4 * i));
      if (i == 4) chk("full_after4", {31'b0, ras_full}, 32'd1);
    end
    call_hint = 1'b0;
    chk("full_after5", {31'b0, ras_full}, 32'd1);
    ret_hint = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pop_pc", pc, 32'h50 - 32'(16 * i));
      chk("pop_not_full", {31'b0, ras_full}, 32'd0);
    end
    chk("pop4_empty", {31'b0, ras_empty}, 32'd1);
    tick(); ret_hint = 1'b0;
    chk("pop5_seq", pc, 32'h24);
    chk("pop5_empty", {31'b0, ras_empty}, 32'd1);

    // Wrap modulo 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0;
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero", pc, 32'h0);

    // Back-to-back redirects; the second carries a call that must still push
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("b2b_1", pc, 32'h200);
    redirect_pc = 32'h400; call_hint = 1'b1; call_link = 32'h404;
    tick(); redirect_valid = 1'b0; call_hint = 1'b0;
    chk("b2b_2", pc, 32'h400);
    chk("redir_call_push", {31'b0, ras_empty}, 32'd0);
    ret_hint = 1'b1;
    tick(); ret_hint = 1'b0;
    chk("redir_call_ret", pc, 32'h404);

    // Simultaneous call and return swap the top
    call_hint = 1'b1; call_link = 32'hA0;
    tick();
    ret_hint = 1'b1; call_link = 32'hB0;
    tick(); call_hint = 1'b0;
    chk("swap_pc", pc, 32'hA0);
    chk("swap_nonempty", {31'b0, ras_empty}, 32'd0);
    tick(); ret_hint = 1'b0;
    chk("swap_ret", pc, 32'hB0);
    chk("swap_empty", {31'b0, ras_empty}, 32'd1);

    // Trap keeps RAS contents; mid-run reset clears everything
    call_hint = 1'b1; call_link = 32'hC0;
    tick(); call_hint = 1'b0;
    trap_valid = 1'b1; trap_vector = 32'h4000_0002;
    tick(); trap_valid = 1'b0;
    chk("trap_mis_pc", pc, 32'h4000_0000);
    chk("trap_mis_flag", {31'b0, misaligned}, 32'd1);
    chk("trap_keeps_ras", {31'b0, ras_empty}, 32'd0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_valid", {31'b0, pc_valid}, 32'd0);
    chk("midrst_empty", {31'b0, ras_empty}, 32'd1);
    chk("midrst_mis", {31'b0, misaligned}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
